uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- UART transmit engine. Drains bytes from the TX-side UART FIFO's read port and serialises each one onto txd_o as an asynchronous frame.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Sits between the TX FIFO (read side: rd/empty/rdata, show-ahead) and the pad. The frame config comes from the UART CSR block.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must equal the TX FIFO width.
- DIV_BITS, 16, width of the baud divisor.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous active-low reset.
- en_i  input  1  transmitter enable; gates fetching of new bytes only.
- baud_div_i  input  DIV_BITS  clocks per bit minus 1.
- parity_en_i  input  1  parity bit is appended when high.
- parity_odd_i  input  1  selects odd parity (1) or even parity (0).
- stop2_i  input  1  selects two stop bits (1) or one (0).
- fifo_empty_i  input  1  TX FIFO empty flag.
- fifo_rdata_i  input  DATA_WIDTH  TX FIFO head data; valid combinationally whenever the FIFO is not empty.
- fifo_rd_o  output  1  TX FIFO pop strobe.
- txd_o  output  1  serial output; idles high.
- busy_o  output  1  high while a frame is in progress.
- done_o  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Clock clk_i; reset rstn_i, asynchronous, active-low.
- Reset values: txd_o=1, busy_o=0, done_o=0, fifo_rd_o=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP.
- fifo_rd_o is combinational: en_i & ~fifo_empty_i & (state==IDLE | last_stop_tick). It is never asserted while fifo_empty_i=1, so the FIFO never underflows.
- On any cycle with fifo_rd_o=1, the following are latched on the same edge:
  - shift register <= fifo_rdata_i
  - baud_div_i, parity_en_i, parity_odd_i, stop2_i into shadow registers
  - parity <= ^fifo_rdata_i ^ parity_odd_i
  - state <= START; bit counter <= baud_div_i
- CSR input changes mid-frame have no effect on the frame in flight.
- txd_o is registered:
  - 0 in START
  - shift[0] in DATA
  - parity in PARITY
  - 1 in STOP and IDLE
- First start-bit cycle on txd_o is the cycle after the pop edge.
- Bit timing:
  - The down-counter reloads with the shadow divisor at each bit boundary.
  - tick = (counter==0). Each bit lasts shadow_div+1 cycles.
  - baud_div_i=0 gives 1 cycle per bit.
- Transitions, all on tick:
  - START -> DATA, bit index 0.
  - DATA shifts right and increments the index. After index DATA_WIDTH-1 it goes to PARITY if parity is enabled, else STOP.
  - PARITY -> STOP.
  - STOP lasts 1 or 2 bit periods (per shadow stop2).
- last_stop_tick = tick in the final stop bit. On that cycle done_o=1 and:
  - If a fetch occurs, go straight to START. Back-to-back frames have zero idle gap.
  - Otherwise go to IDLE.
- busy_o = (state != IDLE).
- Frame length = (1 + DATA_WIDTH + parity_en + 1 + stop2) * (div+1) cycles.
- en_i deasserted mid-frame: the current frame completes normally, and no further fetch happens.
- Reset asserted mid-frame: txd_o goes high immediately (asynchronous) and the FSM returns to IDLE. The partially sent byte is lost.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0
  - the default DATA_WIDTH and DIV_BITS constants
- One natural sub-module: uart_baud_cnt, a down-counter with load/reload and tick output. It can be reused by the RX sampler.

Test Plan:
- 0x55, div=3, no parity, 1 stop -> fifo_rd_o pulses once. txd_o is 0,1,0,1,0,1,0,1,0,1 (start, data LSB-first, stop), each bit 4 cycles, 40 cycles total, then done_o pulses once.
- 0xA5, parity_en=1, even -> parity bit 0. With parity_odd_i=1 -> parity bit 1. Frame length is 11 bit periods.
- Two bytes 0x01, 0x80 preloaded, div=0, stop2=1 -> the second start bit immediately follows the second stop bit of frame 1. busy_o stays high for 22 cycles; done_o pulses at cycles 11 and 22.
- FIFO empty with en_i=1 for 100 cycles -> fifo_rd_o stays 0, txd_o stays 1, busy_o stays 0. With en_i=0 and the FIFO non-empty -> no pop.
- Change baud_div_i 3->7 and stop2_i during DATA -> the current frame keeps 4-cycle bits and 1 stop bit. The next frame uses 8-cycle bits and 2 stop bits.
- Assert rstn_i low during bit 3 of a frame -> txd_o=1 in the same cycle, busy_o=0. After release, no done_o and no fifo_rd_o until the FIFO is non-empty with en_i=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and default widths.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_DIV_BITS   = 16;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate down-counter: explicit load, automatic reload at zero while running,
// and a tick on the last cycle of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned DIV_BITS = UART_DIV_BITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                load_i,
  input  logic [DIV_BITS-1:0] load_val_i,
  input  logic                run_i,
  input  logic [DIV_BITS-1:0] reload_val_i,
  output logic                tick_o
);

  logic [DIV_BITS-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (run_i) begin
      if (cnt_q == '0) cnt_q <= reload_val_i;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = run_i & (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from a show-ahead TX FIFO and shifts them out
// as start / data (LSB first) / optional parity / 1-2 stop bit frames.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DIV_BITS   = UART_DIV_BITS
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic [DIV_BITS-1:0]   baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_o,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  stop_idx_q;
  logic [DIV_BITS-1:0]   div_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  parity_q;
  logic                  txd_q;
  logic                  tick;
  logic                  last_stop_tick;
  logic                  fetch;

  uart_baud_cnt #(
    .DIV_BITS(DIV_BITS)
  ) u_baud_cnt (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .load_i      (fetch),
    .load_val_i  (baud_div_i),
    .run_i       (state_q != IDLE),
    .reload_val_i(div_q),
    .tick_o      (tick)
  );

  assign shift_nxt      = shift_q >> 1;
  assign last_stop_tick = (state_q == STOP) & tick & (stop_idx_q == stop2_q);
  assign fetch          = en_i & ~fifo_empty_i & ((state_q == IDLE) | last_stop_tick);

  // txd_q is loaded with the level of the bit being entered, so it changes on
  // the same edge as the state rather than one cycle later.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= UART_IDLE_LVL;
    end else if (fetch) begin
      shift_q    <= fifo_rdata_i;
      div_q      <= baud_div_i;
      par_en_q   <= parity_en_i;
      stop2_q    <= stop2_i;
      parity_q   <= ^fifo_rdata_i ^ parity_odd_i;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      state_q    <= START;
      txd_q      <= UART_START_LVL;
    end else if (tick) begin
      unique case (state_q)
        START: begin
          state_q   <= DATA;
          bit_idx_q <= '0;
          txd_q     <= shift_q[0];
        end
        DATA: begin
          if (bit_idx_q == LAST_IDX) begin
            stop_idx_q <= 1'b0;
            if (par_en_q) begin
              state_q <= PARITY;
              txd_q   <= parity_q;
            end else begin
              state_q <= STOP;
              txd_q   <= UART_IDLE_LVL;
            end
          end else begin
            shift_q   <= shift_nxt;
            bit_idx_q <= bit_idx_q + 1'b1;
            txd_q     <= shift_nxt[0];
          end
        end
        PARITY: begin
          state_q    <= STOP;
          stop_idx_q <= 1'b0;
          txd_q      <= UART_IDLE_LVL;
        end
        STOP: begin
          if (stop_idx_q == stop2_q) begin
            state_q <= IDLE;
            txd_q   <= UART_IDLE_LVL;
          end else begin
            stop_idx_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= UART_IDLE_LVL;
        end
      endcase
    end
  end

  assign fifo_rd_o = fetch;
  assign txd_o     = txd_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = last_stop_tick;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame vectors from a table plus
// back-to-back, shadowed-CSR, idle/enable and mid-frame reset sequences.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [15:0] baud_div;
  logic        par_en;
  logic        par_odd;
  logic        stop2;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd;
  logic        txd;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DATA_WIDTH(8),
    .DIV_BITS  (16)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .en_i        (en),
    .baud_div_i  (baud_div),
    .parity_en_i (par_en),
    .parity_odd_i(par_odd),
    .stop2_i     (stop2),
    .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata),
    .fifo_rd_o   (fifo_rd),
    .txd_o       (txd),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Show-ahead FIFO model: bench pushes, DUT pops.
  logic [7:0]  fmem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pop_cnt = 0;
  int unsigned underflow_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fmem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (wr_ptr == rd_ptr) underflow_cnt <= underflow_cnt + 1;
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  logic txd_log [0:511];
  int   done_pos [0:7];
  int   ndone;
  int   busy_len;

  task automatic log_cycle(input int cyc, input int change_at);
    if (cyc < 512) txd_log[cyc] = txd;
    if (done && ndone < 8) begin
      done_pos[ndone] = cyc;
      ndone++;
    end
    if (cyc == change_at) begin
      baud_div = 16'd7;
      stop2    = 1'b1;
    end
  endtask

  // Records txd per cycle (cycle 1 = first busy cycle) until busy falls.
  task automatic run_burst(input int change_at);
    int cyc;
    bit started;
    ndone    = 0;
    busy_len = 0;
    started  = 0;
    cyc      = 0;
    for (int i = 0; i < 512; i++) txd_log[i] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin
        started = 1;
        break;
      end
    end
    if (!started) begin
      chk("busy_start_timeout", 32'd0, 32'd1);
      return;
    end
    cyc = 1;
    log_cycle(cyc, change_at);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      log_cycle(cyc, change_at);
    end
    if (busy) chk("busy_end_timeout", 32'd0, 32'd1);
    busy_len = cyc;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic        par_bit;
    int          len;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned pops0;
    int viol_rd, viol_txd, viol_busy, viol_done;
    int nb, k, span;
    logic [15:0] exp_bits, got_bits;

    vecs[0] = '{data: 8'h55, div: 16'd3, par_en: 1'b0, par_odd: 1'b0, stop2: 1'b0, par_bit: 1'b0, len: 40};
    vecs[1] = '{data: 8'hA5, div: 16'd1, par_en: 1'b1, par_odd: 1'b0, stop2: 1'b0, par_bit: 1'b0, len: 22};
    vecs[2] = '{data: 8'hA5, div: 16'd1, par_en: 1'b1, par_odd: 1'b1, stop2: 1'b0, par_bit: 1'b1, len: 22};
    vecs[3] = '{data: 8'h00, div: 16'd0, par_en: 1'b1, par_odd: 1'b1, stop2: 1'b1, par_bit: 1'b1, len: 12};
    vecs[4] = '{data: 8'hFF, div: 16'd2, par_en: 1'b1, par_odd: 1'b0, stop2: 1'b1, par_bit: 1'b0, len: 36};
    vecs[5] = '{data: 8'h3C, div: 16'd0, par_en: 1'b0, par_odd: 1'b0, stop2: 1'b0, par_bit: 1'b0, len: 10};
    vecs[6] = '{data: 8'h80, div: 16'd4, par_en: 1'b1, par_odd: 1'b1, stop2: 1'b0, par_bit: 1'b0, len: 55};

    rstn = 1'b0; en = 1'b0; baud_div = 16'd3; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    rstn = 1'b1;

    // Empty FIFO, enabled: nothing happens.
    en = 1'b1;
    viol_rd = 0; viol_txd = 0; viol_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd) viol_rd++;
      if (!txd) viol_txd++;
      if (busy) viol_busy++;
    end
    chk("idle_empty_rd", viol_rd, 0);
    chk("idle_empty_txd", viol_txd, 0);
    chk("idle_empty_busy", viol_busy, 0);

    // Data available but disabled: no pop.
    en = 1'b0; baud_div = 16'd0;
    pops0 = pop_cnt;
    push(8'h3C);
    viol_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) viol_busy++;
    end
    chk("disabled_pops", pop_cnt - pops0, 0);
    chk("disabled_busy", viol_busy, 0);
    en = 1'b1;
    run_burst(-1);
    chk("enable_len", busy_len, 10);
    chk("enable_pops", pop_cnt - pops0, 1);

    // Table of single frames.
    for (int v = 0; v < 7; v++) begin
      baud_div = vecs[v].div; par_en = vecs[v].par_en;
      par_odd  = vecs[v].par_odd; stop2 = vecs[v].stop2;
      pops0 = pop_cnt;
      push(vecs[v].data);
      run_burst(-1);
      nb = 10 + int'(vecs[v].par_en) + int'(vecs[v].stop2);
      span = int'(vecs[v].div) + 1;
      exp_bits = '0;
      for (int i = 0; i < 8; i++) exp_bits[1 + i] = vecs[v].data[i];
      k = 9;
      if (vecs[v].par_en) begin
        exp_bits[k] = vecs[v].par_bit;
        k++;
      end
      exp_bits[k] = 1'b1;
      if (vecs[v].stop2) exp_bits[k + 1] = 1'b1;
      got_bits = '0;
      for (int b = 0; b < nb; b++) got_bits[b] = txd_log[b * span + 1 + int'(vecs[v].div) / 2];
      chk($sformatf("vec%0d_bits", v), got_bits, exp_bits);
      chk($sformatf("vec%0d_len", v), busy_len, vecs[v].len);
      chk($sformatf("vec%0d_pops", v), pop_cnt - pops0, 1);
      chk($sformatf("vec%0d_done_at_end", v), (ndone == 1 && done_pos[0] == vecs[v].len) ? 1 : 0, 1);
      chk($sformatf("vec%0d_idle_txd", v), txd, 1'b1);
    end

    // Back-to-back frames, zero gap.
    en = 1'b0; baud_div = 16'd0; par_en = 1'b0; stop2 = 1'b1;
    push(8'h01); push(8'h80);
    @(negedge clk);
    en = 1'b1;
    run_burst(-1);
    chk("b2b_busy_len", busy_len, 22);
    chk("b2b_ndone", ndone, 2);
    chk("b2b_done1", done_pos[0], 11);
    chk("b2b_done2", done_pos[1], 22);
    chk("b2b_stop2_f1", txd_log[11], 1'b1);
    chk("b2b_start_f2", txd_log[12], 1'b0);
    chk("b2b_f1_bit0", txd_log[2], 1'b1);
    chk("b2b_f2_bit0", txd_log[13], 1'b0);
    chk("b2b_f2_bit7", txd_log[20], 1'b1);

    // CSR change mid-frame: first frame keeps div=3/1 stop, next takes div=7/2 stop.
    baud_div = 16'd3; stop2 = 1'b0; par_en = 1'b0;
    push(8'h0F); push(8'hF1);
    run_burst(10);
    chk("shadow_busy_len", busy_len, 128);
    chk("shadow_ndone", ndone, 2);
    chk("shadow_done1", done_pos[0], 40);
    chk("shadow_done2", done_pos[1], 128);
    chk("shadow_f1_bit3_end", txd_log[20], 1'b1);
    chk("shadow_f1_bit4_begin", txd_log[21], 1'b0);
    chk("shadow_f1_stop", txd_log[37], 1'b1);
    chk("shadow_f2_start_end", txd_log[48], 1'b0);
    chk("shadow_f2_bit0", txd_log[49], 1'b1);
    chk("shadow_f2_stop2", txd_log[121], 1'b1);
    baud_div = 16'd3; stop2 = 1'b0;

    // Reset during data bit 3 of an all-zero byte.
    pops0 = pop_cnt;
    push(8'h00);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin
        k = 1;
        break;
      end
    end
    chk("rstmid_started", k, 1);
    repeat (17) @(negedge clk);
    chk("rstmid_pre_txd", txd, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rstmid_txd", txd, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    viol_rd = 0; viol_done = 0; viol_busy = 0; viol_txd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_rd) viol_rd++;
      if (done) viol_done++;
      if (busy) viol_busy++;
      if (!txd) viol_txd++;
    end
    chk("rstmid_no_rd", viol_rd, 0);
    chk("rstmid_no_done", viol_done, 0);
    chk("rstmid_idle", viol_busy + viol_txd, 0);
    chk("rstmid_pops", pop_cnt - pops0, 1);

    baud_div = 16'd0;
    push(8'h5A);
    run_burst(-1);
    chk("post_rst_len", busy_len, 10);
    chk("post_rst_done", ndone, 1);
    chk("no_underflow", underflow_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
